// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma rotor sequencer: state encoding,
// lookup table-id mapping and mod-26 arithmetic.
package enigma_pkg;

  localparam int unsigned ALPHA = 26;

  typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BWD, DONE} state_t;

  function automatic int unsigned tab_fwd(input int unsigned r);
    return r;
  endfunction

  function automatic int unsigned tab_refl(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned tab_bwd(input int unsigned n, input int unsigned r);
    return n + 1 + r;
  endfunction

  // Both operands are already in 0..25, so one conditional subtract suffices.
  function automatic logic [4:0] mod_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[5]) d = d + 6'(ALPHA);
    return d[4:0];
  endfunction

endpackage

// File: rtl/enigma_rotor_step.sv
// Combinational odometer stepping for the rotor stack, including the
// middle-rotor double-step.
module enigma_rotor_step
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_ROTORS = 3,
  parameter logic [5*NUM_ROTORS-1:0] NOTCHES = {5'd16, 5'd4, 5'd21}
) (
  input  logic [5*NUM_ROTORS-1:0] pos,
  output logic [5*NUM_ROTORS-1:0] next
);

  logic adv;

  always_comb begin
    next = pos;
    adv  = 1'b0;
    next[4:0] = mod_add(pos[4:0], 5'd1);
    // A rotor sitting on its own notch drags itself along with its left
    // neighbour; the leftmost rotor has nothing to drag, so it is excluded.
    for (int unsigned r = 1; r < NUM_ROTORS; r++) begin
      adv = (pos[5*(r-1) +: 5] == NOTCHES[5*(r-1) +: 5]) ||
            ((r < NUM_ROTORS - 1) && (pos[5*r +: 5] == NOTCHES[5*r +: 5]));
      if (adv) next[5*r +: 5] = mod_add(pos[5*r +: 5], 5'd1);
    end
  end

endmodule

// File: rtl/enigma_rotor_seq.sv
// Enigma letter sequencer: steps the rotors, then walks one letter through
// the shared substitution lookup forward, via the reflector, and back.
module enigma_rotor_seq
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned ALPHA = 26,
  parameter logic [5*NUM_ROTORS-1:0] NOTCHES = {5'd16, 5'd4, 5'd21},
  parameter int unsigned TAB_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_idx,
  input  logic                    cfg_load,
  input  logic [5*NUM_ROTORS-1:0] cfg_pos,
  output logic [5*NUM_ROTORS-1:0] rot_pos,
  output logic [TAB_W-1:0]        lut_tab,
  output logic [31:0]             lut_sel,
  input  logic [7:0]              lut_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_idx,
  output logic                    out_err
);

  localparam int unsigned PW = $clog2(NUM_ROTORS + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_ROTORS - 1);

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [4:0]              cur;
  logic                    err;
  logic [4:0]              cur_pos;
  logic [4:0]              nxt_cur;
  logic                    res_ok;
  logic [5*NUM_ROTORS-1:0] step_next;
  logic [5*NUM_ROTORS-1:0] cfg_clean;

  enigma_rotor_step #(
    .NUM_ROTORS(NUM_ROTORS),
    .NOTCHES   (NOTCHES)
  ) u_step (
    .pos (rot_pos),
    .next(step_next)
  );

  assign in_ready = (state == IDLE) && !cfg_load;

  always_comb begin
    cfg_clean = '0;
    for (int unsigned r = 0; r < NUM_ROTORS; r++)
      if (cfg_pos[5*r +: 5] < 5'(ALPHA)) cfg_clean[5*r +: 5] = cfg_pos[5*r +: 5];
  end

  always_comb begin
    cur_pos = '0;
    for (int unsigned r = 0; r < NUM_ROTORS; r++)
      if (PW'(r) == ptr) cur_pos = rot_pos[5*r +: 5];
    lut_tab = '0;
    lut_sel = '0;
    case (state)
      FWD: begin
        lut_tab = TAB_W'(tab_fwd(32'(ptr)));
        lut_sel = 32'(mod_add(cur, cur_pos));
      end
      REFL: begin
        lut_tab = TAB_W'(tab_refl(NUM_ROTORS));
        lut_sel = 32'(cur);
      end
      BWD: begin
        lut_tab = TAB_W'(tab_bwd(NUM_ROTORS, 32'(ptr)));
        lut_sel = 32'(mod_add(cur, cur_pos));
      end
      default: ;
    endcase
    res_ok  = lut_res < 8'(ALPHA);
    nxt_cur = (state == REFL) ? lut_res[4:0] : mod_sub(lut_res[4:0], cur_pos);
    if (!res_ok) nxt_cur = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      err       <= 1'b0;
      rot_pos   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            rot_pos <= cfg_clean;
          end else if (in_valid) begin
            err <= 1'b0;
            if (in_idx < 8'(ALPHA)) begin
              cur   <= in_idx[4:0];
              state <= STEP;
            end else begin
              out_idx   <= in_idx;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        STEP: begin
          rot_pos <= step_next;
          ptr     <= '0;
          state   <= FWD;
        end
        FWD: begin
          cur <= nxt_cur;
          err <= err | !res_ok;
          if (ptr == LAST) state <= REFL;
          else ptr <= ptr + 1'b1;
        end
        REFL: begin
          cur   <= nxt_cur;
          err   <= err | !res_ok;
          ptr   <= LAST;
          state <= BWD;
        end
        BWD: begin
          cur <= nxt_cur;
          err <= err | !res_ok;
          if (ptr == '0) begin
            out_idx   <= {3'b000, nxt_cur};
            out_err   <= err | !res_ok;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_seq.sv
// Directed bench for enigma_rotor_seq with identity rotor tables and a
// 25-x reflector modelled as a combinational lookup.
module tb_enigma_rotor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_idx = '0;
  logic        cfg_load = 1'b0;
  logic [14:0] cfg_pos = '0;
  logic [14:0] rot_pos;
  logic [2:0]  lut_tab;
  logic [31:0] lut_sel;
  logic [7:0]  lut_res;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_idx;
  logic        out_err;
  logic        inject_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  enigma_rotor_seq #(
    .NUM_ROTORS(3),
    .ALPHA     (26),
    .NOTCHES   ({5'd16, 5'd4, 5'd21}),
    .TAB_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .cfg_load (cfg_load),
    .cfg_pos  (cfg_pos),
    .rot_pos  (rot_pos),
    .lut_tab  (lut_tab),
    .lut_sel  (lut_sel),
    .lut_res  (lut_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (lut_tab == 3'd3) lut_res = inject_err ? 8'd30 : (8'd25 - lut_sel[7:0]);
    else lut_res = lut_sel[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic accept(input logic [7:0] idx);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_idx   = idx;
    tick();
    in_valid = 1'b0;
    in_idx   = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic load(input logic [14:0] p);
    cfg_pos  = p;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({in_ready, out_valid, out_err} !== 3'b100 || rot_pos !== '0 ||
        lut_sel !== '0 || lut_tab !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b pos=%h sel=%0d tab=%0d idx=%0d want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_err, rot_pos, lut_sel, lut_tab, out_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    logic [2:0]  exp_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd5, 3'd4};
    logic [31:0] exp_sel [7] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd25, 32'd25, 32'd0};
    accept(8'd0);
    vectors++;
    if (out_valid !== 1'b0 || lut_tab !== 3'd0 || lut_sel !== 32'd0) begin
      miscompares++;
      $display("FAIL id_step_cycle: vld=%b tab=%0d sel=%0d want 0 0 0", out_valid, lut_tab, lut_sel);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (lut_tab !== exp_tab[i] || lut_sel !== exp_sel[i] || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL id_lookup[%0d]: tab=%0d sel=%0d vld=%b want %0d %0d 0",
                 i, lut_tab, lut_sel, out_valid, exp_tab[i], exp_sel[i]);
      end
      if (i == 0) begin
        vectors++;
        if (rot_pos !== 15'd1) begin
          miscompares++;
          $display("FAIL id_rot_pos: got %h want %h", rot_pos, 15'd1);
        end
      end
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 8'd25 || out_err !== 1'b0 || lut_sel !== '0) begin
      miscompares++;
      $display("FAIL id_result: vld=%b idx=%0d err=%b sel=%0d want 1 25 0 0",
               out_valid, out_idx, out_err, lut_sel);
    end
    drain();
  endtask

  task automatic test_double_step();
    logic [14:0] exp_pos [3] = '{{5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}, {5'd1, 5'd5, 5'd24}};
    logic [31:0] exp_sel [3] = '{32'd3, 32'd4, 32'd5};
    load({5'd0, 5'd3, 5'd21});
    vectors++;
    if (rot_pos !== {5'd0, 5'd3, 5'd21}) begin
      miscompares++;
      $display("FAIL ds_load: got %h want %h", rot_pos, {5'd0, 5'd3, 5'd21});
    end
    for (int k = 0; k < 3; k++) begin
      accept(8'd7);
      tick();
      vectors++;
      if (lut_tab !== 3'd0 || lut_sel !== exp_sel[k]) begin
        miscompares++;
        $display("FAIL ds_first_sel[%0d]: tab=%0d sel=%0d want 0 %0d", k, lut_tab, lut_sel, exp_sel[k]);
      end
      wait_done();
      vectors++;
      if (out_idx !== 8'd18 || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL ds_out[%0d]: idx=%0d err=%b want 18 0", k, out_idx, out_err);
      end
      drain();
      vectors++;
      if (rot_pos !== exp_pos[k]) begin
        miscompares++;
        $display("FAIL ds_pos[%0d]: got %h want %h", k, rot_pos, exp_pos[k]);
      end
    end
  endtask

  task automatic test_wrap();
    load({5'd0, 5'd0, 5'd25});
    accept(8'd10);
    wait_done();
    vectors++;
    if (out_idx !== 8'd15) begin
      miscompares++;
      $display("FAIL wrap_out: got %0d want 15", out_idx);
    end
    drain();
    vectors++;
    if (rot_pos !== 15'd0) begin
      miscompares++;
      $display("FAIL wrap_pos: got %h want 0", rot_pos);
    end
    load({5'd30, 5'd7, 5'd26});
    vectors++;
    if (rot_pos !== {5'd0, 5'd7, 5'd0}) begin
      miscompares++;
      $display("FAIL cfg_clamp: got %h want %h", rot_pos, {5'd0, 5'd7, 5'd0});
    end
  endtask

  task automatic test_nonletter();
    accept(8'd32);
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 8'd32 || out_err !== 1'b0 || lut_sel !== '0 ||
        lut_tab !== '0 || rot_pos !== {5'd0, 5'd7, 5'd0}) begin
      miscompares++;
      $display("FAIL nonletter: vld=%b idx=%0d err=%b sel=%0d tab=%0d pos=%h want 1 32 0 0 0 %h",
               out_valid, out_idx, out_err, lut_sel, lut_tab, rot_pos, {5'd0, 5'd7, 5'd0});
    end
    drain();
  endtask

  task automatic test_backpressure();
    accept(8'd4);
    wait_done();
    for (int c = 0; c < 5; c++) begin
      cfg_load = 1'b1;
      cfg_pos  = {5'd1, 5'd1, 5'd1};
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 8'd21 || in_ready !== 1'b0 ||
          rot_pos !== {5'd0, 5'd7, 5'd1}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: vld=%b idx=%0d rdy=%b pos=%h want 1 21 0 %h",
                 c, out_valid, out_idx, in_ready, rot_pos, {5'd0, 5'd7, 5'd1});
      end
      tick();
    end
    cfg_load = 1'b0;
    drain();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rot_pos !== {5'd0, 5'd7, 5'd1}) begin
      miscompares++;
      $display("FAIL bp_release: vld=%b rdy=%b pos=%h want 0 1 %h",
               out_valid, in_ready, rot_pos, {5'd0, 5'd7, 5'd1});
    end
  endtask

  task automatic test_error();
    inject_err = 1'b1;
    accept(8'd2);
    wait_done();
    vectors++;
    if (out_err !== 1'b1 || out_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL err_set: err=%b idx=%0d want 1 0", out_err, out_idx);
    end
    drain();
    inject_err = 1'b0;
    accept(8'd2);
    wait_done();
    vectors++;
    if (out_err !== 1'b0 || out_idx !== 8'd23) begin
      miscompares++;
      $display("FAIL err_clear: err=%b idx=%0d want 0 23", out_err, out_idx);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    accept(8'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rot_pos !== '0 ||
        lut_sel !== '0 || lut_tab !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b vld=%b pos=%h sel=%0d tab=%0d want 1 0 0 0 0",
               in_ready, out_valid, rot_pos, lut_sel, lut_tab);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_emit: out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_double_step();
    test_wrap();
    test_nonletter();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
